// File: rtl/matrix_host_inventory.sv
// Gen2 host inventory-round controller: Query/QueryRep/ACK issue,
// per-slot reply classification and tag/collision/empty statistics.
module matrix_host_inventory #(
  parameter int Tp = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        h_StartHInvRound,
  input  logic [3:0]  h_Q,
  output logic        h_EndHinvRound,
  output logic        t_CmdReq,
  output logic [1:0]  t_CmdType,
  input  logic        t_CmdAck,
  input  logic        r_RespValid,
  input  logic [1:0]  r_RespType,
  output logic        h_EpcStore,
  output logic [15:0] h_TagCount,
  output logic [15:0] h_CollCount,
  output logic [15:0] h_EmptyCount,
  output logic [6:0]  HinvState
);

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_QUERY = 7'b0000010,
    S_WRN16 = 7'b0000100,
    S_ACK   = 7'b0001000,
    S_WEPC  = 7'b0010000,
    S_REP   = 7'b0100000,
    S_DONE  = 7'b1000000
  } state_t;

  localparam logic [1:0] C_QUERY = 2'd0;
  localparam logic [1:0] C_REP   = 2'd1;
  localparam logic [1:0] C_ACK   = 2'd2;

  localparam logic [1:0] R_TMO  = 2'd0;
  localparam logic [1:0] R_RN16 = 2'd1;
  localparam logic [1:0] R_EPC  = 2'd2;

  state_t      r_State;
  state_t      w_NextState;
  logic        r_StartD;
  logic [15:0] r_SlotCnt;
  logic [15:0] w_SlotNxt;
  logic [15:0] r_Tag;
  logic [15:0] w_TagNxt;
  logic [15:0] r_Coll;
  logic [15:0] w_CollNxt;
  logic [15:0] r_Empty;
  logic [15:0] w_EmptyNxt;
  logic        r_Epc;
  logic        w_EpcNxt;
  logic        r_CmdReq;
  logic        w_ReqNxt;
  logic [1:0]  r_CmdType;
  logic [1:0]  w_TypeNxt;
  logic        w_Decide;
  logic        w_NextSlot;
  logic        w_StartEdge;
  logic [15:0] w_SlotLoad;
  logic        w_unused_tp;

  // Tp is a simulation-only delay; the RTL itself carries no delays.
  assign w_unused_tp = (Tp != 0);

  assign w_StartEdge = h_StartHInvRound & ~r_StartD;
  assign w_SlotLoad  = (16'd1 << h_Q) - 16'd1;

  function automatic logic [15:0] f_SatInc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next state, slot/statistic updates and registered command request.
  always_comb begin
    w_NextState = r_State;
    w_SlotNxt   = r_SlotCnt;
    w_TagNxt    = r_Tag;
    w_CollNxt   = r_Coll;
    w_EmptyNxt  = r_Empty;
    w_EpcNxt    = 1'b0;
    w_ReqNxt    = 1'b0;
    w_TypeNxt   = 2'd0;
    w_Decide    = 1'b0;
    w_NextSlot  = 1'b0;
    unique case (1'b1)
      r_State[0]: begin
        if (w_StartEdge) begin
          w_NextState = S_QUERY;
          w_SlotNxt   = w_SlotLoad;
          w_TagNxt    = 16'd0;
          w_CollNxt   = 16'd0;
          w_EmptyNxt  = 16'd0;
        end
      end
      r_State[1], r_State[5]: begin
        if (t_CmdAck) begin
          w_Decide    = 1'b1;
          w_NextState = S_WRN16;
        end
      end
      r_State[2]: begin
        if (r_RespValid) begin
          w_Decide = 1'b1;
          if (r_RespType == R_RN16) begin
            w_NextState = S_ACK;
          end else if (r_RespType == R_TMO) begin
            w_EmptyNxt = f_SatInc(r_Empty);
            w_NextSlot = 1'b1;
          end else begin
            w_CollNxt  = f_SatInc(r_Coll);
            w_NextSlot = 1'b1;
          end
        end
      end
      r_State[3]: begin
        if (t_CmdAck) begin
          w_Decide    = 1'b1;
          w_NextState = S_WEPC;
        end
      end
      r_State[4]: begin
        if (r_RespValid) begin
          w_Decide   = 1'b1;
          w_NextSlot = 1'b1;
          if (r_RespType == R_EPC) begin
            w_TagNxt = f_SatInc(r_Tag);
            w_EpcNxt = 1'b1;
          end else begin
            w_CollNxt = f_SatInc(r_Coll);
          end
        end
      end
      r_State[6]: begin
        w_NextState = S_IDLE;
      end
      default: begin
        w_NextState = S_IDLE;
      end
    endcase
    if (w_NextSlot) begin
      if (r_SlotCnt == 16'd0) begin
        w_NextState = S_DONE;
      end else begin
        w_SlotNxt   = r_SlotCnt - 16'd1;
        w_NextState = S_REP;
      end
    end
    // Sequencer left HST_INV: count the event but drop the round.
    if (w_Decide && !h_StartHInvRound) begin
      w_NextState = S_IDLE;
    end
    unique case (1'b1)
      w_NextState[1]: begin
        w_ReqNxt  = 1'b1;
        w_TypeNxt = C_QUERY;
      end
      w_NextState[3]: begin
        w_ReqNxt  = 1'b1;
        w_TypeNxt = C_ACK;
      end
      w_NextState[5]: begin
        w_ReqNxt  = 1'b1;
        w_TypeNxt = C_REP;
      end
      default: begin
        w_ReqNxt  = 1'b0;
        w_TypeNxt = 2'd0;
      end
    endcase
  end

  // State, statistics and registered TX request.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_State   <= S_IDLE;
      r_StartD  <= 1'b0;
      r_SlotCnt <= 16'd0;
      r_Tag     <= 16'd0;
      r_Coll    <= 16'd0;
      r_Empty   <= 16'd0;
      r_Epc     <= 1'b0;
      r_CmdReq  <= 1'b0;
      r_CmdType <= 2'd0;
    end else begin
      r_State   <= w_NextState;
      r_StartD  <= h_StartHInvRound;
      r_SlotCnt <= w_SlotNxt;
      r_Tag     <= w_TagNxt;
      r_Coll    <= w_CollNxt;
      r_Empty   <= w_EmptyNxt;
      r_Epc     <= w_EpcNxt;
      r_CmdReq  <= w_ReqNxt;
      r_CmdType <= w_TypeNxt;
    end
  end

  assign h_EndHinvRound = (r_State == S_DONE);
  assign t_CmdReq       = r_CmdReq;
  assign t_CmdType      = r_CmdType;
  assign h_EpcStore     = r_Epc;
  assign h_TagCount     = r_Tag;
  assign h_CollCount    = r_Coll;
  assign h_EmptyCount   = r_Empty;
  assign HinvState      = r_State;

endmodule
